// File: rtl/ikaopm_bus_sequencer_pkg.sv
// Purpose: shared encodings for the OPM host bus sequencer (states, status bits, defaults).
// Latency: n/a (types and constants only).
// Backpressure: n/a; the host observes BUSY through the status byte instead.
package ikaopm_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PEND   = 2'd1,
    COMMIT = 2'd2
  } seq_state_t;

  // Minimum BUSY length after a data write, in phi1 cycles (valid 2..32).
  localparam int BUSY_CYCLES_DEF = 32;

  localparam int STAT_BUSY   = 7;
  localparam int STAT_TIMERB = 1;
  localparam int STAT_TIMERA = 0;

  function automatic logic [7:0] status_byte(input logic busy, input logic timerb,
                                             input logic timera);
    logic [7:0] s;
    s              = 8'h00;
    s[STAT_BUSY]   = busy;
    s[STAT_TIMERB] = timerb;
    s[STAT_TIMERA] = timera;
    return s;
  endfunction

endpackage

// File: rtl/ikaopm_bus_sequencer_if.sv
// Purpose: host bus pins between the CPU and the OPM bus sequencer.
// Latency: n/a (wiring only).
// Backpressure: none on the pins; the host polls BUSY in the status byte.
interface ikaopm_bus_sequencer_if;
  logic       i_CS_n;
  logic       i_WR_n;
  logic       i_RD_n;
  logic       i_A0;
  logic [7:0] i_D;
  logic [7:0] o_D;
  logic       o_D_OE;

  modport master (
    output i_CS_n, i_WR_n, i_RD_n, i_A0, i_D,
    input  o_D, o_D_OE
  );

  modport slave (
    input  i_CS_n, i_WR_n, i_RD_n, i_A0, i_D,
    output o_D, o_D_OE
  );
endinterface

// File: rtl/ikaopm_bus_sequencer_strobe_edge.sv
// Purpose: registers an active-high strobe and flags its first sampled cycle.
// Latency: level is 1 enabled cycle late; rise is combinational against the registered copy.
// Backpressure: none; a held strobe yields a single rise.
module ikaopm_strobe_edge (
  input  logic i_EMUCLK,
  input  logic i_MRST_n,
  input  logic i_phi1_NCEN_n,
  input  logic strobe,
  output logic level,
  output logic rise
);

  logic strobe_d;

  // Sample the strobe once per enabled phi1 edge.
  always_ff @(posedge i_EMUCLK) begin
    if (!i_phi1_NCEN_n) begin
      if (!i_MRST_n) strobe_d <= 1'b0;
      else           strobe_d <= strobe;
    end
  end

  assign level = strobe_d;
  assign rise  = strobe & ~strobe_d;

endmodule

// File: rtl/ikaopm_bus_sequencer.sv
// Purpose: latches host address/data writes, commits data in the CYCLE_31 slot, drives BUSY and status reads.
// Latency: address 1 cycle; commit 1 cycle after PEND sees CYCLE_31; status read 1 cycle.
// Backpressure: none; BUSY stays high until the counter expires and the pending write has committed.
module ikaopm_bus_sequencer
  import ikaopm_pkg::*;
#(
  parameter int BUSY_CYCLES = BUSY_CYCLES_DEF
) (
  input  logic                   i_EMUCLK,
  input  logic                   i_MRST_n,
  input  logic                   i_phi1_NCEN_n,
  ikaopm_bus_sequencer_if.slave  host,
  input  logic                   i_CYCLE_31,
  input  logic                   i_TIMERA_FLAG,
  input  logic                   i_TIMERB_FLAG,
  output logic [7:0]             o_REG_ADDR,
  output logic [7:0]             o_REG_DATA,
  output logic                   o_REG_WE,
  output logic                   o_BUSY
);

  localparam logic [4:0] BUSY_LOAD = 5'(BUSY_CYCLES - 1);

  seq_state_t state, state_nx;
  logic [7:0] addr_lat, data_lat, addr_snap;
  logic [4:0] busy_cnt;
  logic       wr, rd, wr_rise, wr_level, rd_rise, rd_level;
  logic       addr_wr, data_wr;
  logic       unused_strobe;

  assign wr = ~host.i_CS_n & ~host.i_WR_n;
  assign rd = ~host.i_CS_n & ~host.i_RD_n;

  ikaopm_strobe_edge u_wr_edge (
    .i_EMUCLK      (i_EMUCLK),
    .i_MRST_n      (i_MRST_n),
    .i_phi1_NCEN_n (i_phi1_NCEN_n),
    .strobe        (wr),
    .level         (wr_level),
    .rise          (wr_rise)
  );

  // The registered read strobe doubles as the output enable.
  ikaopm_strobe_edge u_rd_edge (
    .i_EMUCLK      (i_EMUCLK),
    .i_MRST_n      (i_MRST_n),
    .i_phi1_NCEN_n (i_phi1_NCEN_n),
    .strobe        (rd),
    .level         (rd_level),
    .rise          (rd_rise)
  );

  // Write level and read rise have no consumer here.
  assign unused_strobe = wr_level ^ rd_rise;

  assign addr_wr = wr_rise & ~host.i_A0;
  assign data_wr = wr_rise &  host.i_A0;

  // Next state: a data write always (re)arms PEND and masks a coincident CYCLE_31.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (data_wr) state_nx = PEND;
      PEND:    if (!data_wr && i_CYCLE_31) state_nx = COMMIT;
      COMMIT:  state_nx = data_wr ? PEND : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge i_EMUCLK) begin
    if (!i_phi1_NCEN_n) begin
      if (!i_MRST_n) state <= IDLE;
      else           state <= state_nx;
    end
  end

  // Host latches; the snapshot freezes the address as of the data write.
  always_ff @(posedge i_EMUCLK) begin
    if (!i_phi1_NCEN_n) begin
      if (!i_MRST_n) begin
        addr_lat  <= 8'h00;
        data_lat  <= 8'h00;
        addr_snap <= 8'h00;
      end else begin
        if (addr_wr) addr_lat <= host.i_D;
        if (data_wr) begin
          data_lat  <= host.i_D;
          addr_snap <= addr_lat;
        end
      end
    end
  end

  // Register-file port: values are presented only when a commit starts.
  always_ff @(posedge i_EMUCLK) begin
    if (!i_phi1_NCEN_n) begin
      if (!i_MRST_n) begin
        o_REG_ADDR <= 8'h00;
        o_REG_DATA <= 8'h00;
        o_REG_WE   <= 1'b0;
      end else begin
        o_REG_WE <= (state_nx == COMMIT);
        if (state == PEND && state_nx == COMMIT) begin
          o_REG_ADDR <= addr_snap;
          o_REG_DATA <= data_lat;
        end
      end
    end
  end

  // BUSY: counter sets the floor, the FSM holds it until the commit has finished.
  always_ff @(posedge i_EMUCLK) begin
    if (!i_phi1_NCEN_n) begin
      if (!i_MRST_n) begin
        busy_cnt <= 5'd0;
        o_BUSY   <= 1'b0;
      end else if (data_wr) begin
        busy_cnt <= BUSY_LOAD;
        o_BUSY   <= 1'b1;
      end else begin
        if (busy_cnt != 5'd0) busy_cnt <= busy_cnt - 5'd1;
        if (busy_cnt == 5'd0 && state_nx == IDLE) o_BUSY <= 1'b0;
      end
    end
  end

  // Status read: capture while the read strobe is sampled, hold otherwise.
  always_ff @(posedge i_EMUCLK) begin
    if (!i_phi1_NCEN_n) begin
      if (!i_MRST_n)  host.o_D <= 8'h00;
      else if (rd)    host.o_D <= status_byte(o_BUSY, i_TIMERB_FLAG, i_TIMERA_FLAG);
    end
  end

  assign host.o_D_OE = rd_level;

endmodule

// File: tb/tb_ikaopm_bus_sequencer.sv
// Purpose: directed checks of write latching, slot commit, overwrite, reset abort and status reads.
// Latency: expected commits queued at write time and popped when o_REG_WE is seen.
// Backpressure: n/a; bench models the 32-cycle slot counter itself.
module tb_ikaopm_bus_sequencer;
  import ikaopm_pkg::*;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
  } commit_t;

  logic       clk = 1'b0;
  logic       mrst_n, ncen_n, cycle31, timera, timerb;
  logic [7:0] reg_addr, reg_data;
  logic       reg_we, busy;
  int         tests = 0;
  int         fails = 0;
  int         phase = 0;
  commit_t    exp_q[$];

  always #5 clk = ~clk;

  ikaopm_bus_sequencer_if host ();

  ikaopm_bus_sequencer #(.BUSY_CYCLES(32)) dut (
    .i_EMUCLK      (clk),
    .i_MRST_n      (mrst_n),
    .i_phi1_NCEN_n (ncen_n),
    .host          (host),
    .i_CYCLE_31    (cycle31),
    .i_TIMERA_FLAG (timera),
    .i_TIMERB_FLAG (timerb),
    .o_REG_ADDR    (reg_addr),
    .o_REG_DATA    (reg_data),
    .o_REG_WE      (reg_we),
    .o_BUSY        (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One phi1 edge; the slot counter only advances on enabled edges.
  task automatic tick();
    @(posedge clk);
    #1;
    if (!ncen_n) phase = (phase + 1) % 32;
    cycle31 = (phase == 31);
  endtask

  task automatic wait_phase(input int p);
    int n;
    n = 0;
    while (phase != p && n < 40) begin
      tick();
      n++;
    end
  endtask

  task automatic host_write(input logic a0, input logic [7:0] d);
    host.i_A0   = a0;
    host.i_D    = d;
    host.i_CS_n = 1'b0;
    host.i_WR_n = 1'b0;
    tick();
    host.i_WR_n = 1'b1;
    host.i_CS_n = 1'b1;
  endtask

  task automatic watch(input int n, output int busy_n, output int we_n, output int we_at);
    commit_t e;
    busy_n = 0;
    we_n   = 0;
    we_at  = -1;
    for (int i = 1; i <= n; i++) begin
      tick();
      if (busy === 1'b1) busy_n++;
      if (reg_we === 1'b1) begin
        we_n++;
        if (we_at < 0) we_at = i;
        tests++;
        assert (exp_q.size() != 0) else begin
          fails++;
          $error("FAIL unexpected_we: observed commit %02h/%02h expected none", reg_addr, reg_data);
        end
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("commit_addr", reg_addr, e.addr);
          check("commit_data", reg_data, e.data);
        end
      end
    end
  endtask

  initial begin
    int b0, bn, wn, wat;
    mrst_n = 1'b0; ncen_n = 1'b0; cycle31 = 1'b0; timera = 1'b0; timerb = 1'b0;
    host.i_CS_n = 1'b1; host.i_WR_n = 1'b1; host.i_RD_n = 1'b1; host.i_A0 = 1'b0; host.i_D = 8'h00;
    repeat (3) tick();
    check("rst_reg_addr", reg_addr, 0);
    check("rst_reg_data", reg_data, 0);
    check("rst_reg_we", reg_we, 0);
    check("rst_busy", busy, 0);
    check("rst_o_d", host.o_D, 0);
    check("rst_o_d_oe", host.o_D_OE, 0);
    mrst_n = 1'b1;
    tick();

    // Strobe seen only on disabled edges produces no event.
    ncen_n = 1'b0;
    ncen_n = 1'b1;
    host.i_A0 = 1'b1; host.i_D = 8'hEE; host.i_CS_n = 1'b0; host.i_WR_n = 1'b0;
    tick(); tick();
    host.i_CS_n = 1'b1; host.i_WR_n = 1'b1;
    ncen_n = 1'b0;
    tick();
    check("disabled_edge_busy", busy, 0);

    // Address 0x20, data 0xC5 two cycles before the slot.
    wait_phase(25);
    host_write(1'b0, 8'h20);
    wait_phase(29);
    exp_q.push_back('{addr: 8'h20, data: 8'hC5});
    host_write(1'b1, 8'hC5);
    b0 = int'(busy === 1'b1);
    watch(40, bn, wn, wat);
    check("basic_we_count", wn, 1);
    check("basic_we_at", wat, 2);
    check("basic_busy_len", b0 + bn, 32);

    // Data write coincident with CYCLE_31 waits a full slot period.
    wait_phase(31);
    exp_q.push_back('{addr: 8'h20, data: 8'h5A});
    host_write(1'b1, 8'h5A);
    b0 = int'(busy === 1'b1);
    watch(40, bn, wn, wat);
    check("slot_we_at", wat, 32);
    check("slot_busy_len", b0 + bn, 33);

    // Overwrite while pending: only the latest data commits, BUSY restarts.
    wait_phase(5);
    exp_q.push_back('{addr: 8'h20, data: 8'h11});
    host_write(1'b1, 8'h11);
    watch(8, bn, wn, wat);
    check("ovr_no_early_we", wn, 0);
    wait_phase(20);
    void'(exp_q.pop_back());
    exp_q.push_back('{addr: 8'h20, data: 8'h22});
    host_write(1'b1, 8'h22);
    b0 = int'(busy === 1'b1);
    watch(40, bn, wn, wat);
    check("ovr_we_count", wn, 1);
    check("ovr_we_at", wat, 11);
    check("ovr_busy_len", b0 + bn, 32);

    // Address write during PEND leaves the snapshot alone.
    wait_phase(5);
    exp_q.push_back('{addr: 8'h20, data: 8'h55});
    host_write(1'b1, 8'h55);
    wait_phase(10);
    host_write(1'b0, 8'h30);
    watch(40, bn, wn, wat);
    check("snap_we_count", wn, 1);
    check("snap_addr_held", reg_addr, 8'h20);
    wait_phase(5);
    exp_q.push_back('{addr: 8'h30, data: 8'h66});
    host_write(1'b1, 8'h66);
    check("snap_addr_before_commit", reg_addr, 8'h20);
    watch(40, bn, wn, wat);
    check("snap_addr_after_commit", reg_addr, 8'h30);

    // Status read while BUSY with TIMERA set.
    wait_phase(5);
    exp_q.push_back('{addr: 8'h30, data: 8'h99});
    host_write(1'b1, 8'h99);
    timera = 1'b1; timerb = 1'b0;
    host.i_CS_n = 1'b0; host.i_RD_n = 1'b0;
    tick();
    check("read_o_d", host.o_D, 8'h81);
    check("read_oe", host.o_D_OE, 1);
    host.i_CS_n = 1'b1; host.i_RD_n = 1'b1;
    tick();
    check("read_oe_release", host.o_D_OE, 0);
    check("read_o_d_hold", host.o_D, 8'h81);
    watch(40, bn, wn, wat);
    check("read_we_count", wn, 1);

    // Simultaneous write and read: read sees pre-write BUSY, write proceeds.
    timera = 1'b1; timerb = 1'b1;
    wait_phase(5);
    exp_q.push_back('{addr: 8'h30, data: 8'hAB});
    host.i_A0 = 1'b1; host.i_D = 8'hAB;
    host.i_CS_n = 1'b0; host.i_WR_n = 1'b0; host.i_RD_n = 1'b0;
    tick();
    host.i_CS_n = 1'b1; host.i_WR_n = 1'b1; host.i_RD_n = 1'b1;
    check("both_o_d", host.o_D, 8'h03);
    check("both_oe", host.o_D_OE, 1);
    check("both_busy", busy, 1);
    watch(40, bn, wn, wat);
    check("both_we_count", wn, 1);
    timera = 1'b0; timerb = 1'b0;

    // Reset while PEND aborts the commit and clears everything.
    wait_phase(5);
    host_write(1'b1, 8'h77);
    tick(); tick();
    mrst_n = 1'b0;
    tick();
    check("abort_reg_addr", reg_addr, 0);
    check("abort_reg_data", reg_data, 0);
    check("abort_reg_we", reg_we, 0);
    check("abort_busy", busy, 0);
    check("abort_o_d", host.o_D, 0);
    check("abort_o_d_oe", host.o_D_OE, 0);
    mrst_n = 1'b1;
    watch(40, bn, wn, wat);
    check("abort_no_we", wn, 0);
    check("abort_no_busy", bn, 0);

    check("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
